// File: rtl/fetch_unit.sv
// fetch_unit: registered-PC instruction fetch front end with a pipelined memory
// request/response interface, a per-request PC tag queue, a credit-controlled
// prefetch FIFO and redirect/flush handling.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (fault port and trap on misaligned redirects).
module fetch_unit #(
    parameter int unsigned     XLEN       = 64,
    parameter int unsigned     ILEN       = 32,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic [ILEN-1:0] if_ix,
    output logic            fault
`else
    output logic [ILEN-1:0] if_ix
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              run;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W-1:0]  discard_next;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  fifo_rd;
    logic [PTR_W-1:0]  fifo_wr;
    logic [PTR_W-1:0]  tag_rd;
    logic [PTR_W-1:0]  tag_wr;
    logic [XLEN-1:0]   fifo_pc [FIFO_DEPTH];
    logic [ILEN-1:0]   fifo_ix [FIFO_DEPTH];
    logic [XLEN-1:0]   tag_q   [FIFO_DEPTH];

    logic              credit_ok;
    logic              flush;
    logic              rsp_push;
    logic              req_fire;
    logic              pop;
    logic [XLEN-1:0]   redirect_target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic              misaligned;
    logic              fault_pend;
    logic              fault_pend_next;

    // Misaligned targets are kept intact so the faulting PC is visible
    assign redirect_target = redirect_pc;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
`else
    // Without the checker, low target bits are simply dropped
    assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

    // In-flight requests plus buffered words may never exceed the FIFO capacity
    assign credit_ok = ((CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_cnt)) < (CNT_W+1)'(FIFO_DEPTH);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign pop       = if_valid && if_ready;

    assign imem_req_addr = pc;
    assign if_pc         = fifo_pc[fifo_rd];
    assign if_ix         = fifo_ix[fifo_rd];

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, redirect handling and handshake outputs
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        discard_next    = discard;
        flush           = 1'b0;
        rsp_push        = 1'b0;
        imem_req_valid  = 1'b0;
        if_valid        = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_pend_next = fault_pend;
        fault           = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush        = 1'b1;
                    pc_next      = redirect_target;
                    discard_next = outstanding - CNT_W'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHK_EN
                    fault_pend_next = misaligned;
`endif
                    if (discard_next != '0) begin
                        state_next = ST_FLUSH;
                    end
`ifdef FETCH_MISALIGN_CHK_EN
                    else if (misaligned) begin
                        state_next = ST_FAULT;
                    end
`endif
                end else begin
                    imem_req_valid = run && credit_ok;
                    if_valid       = (fifo_cnt != '0);
                    rsp_push       = imem_rsp_valid;
                    if (imem_req_valid && imem_req_ready) begin
                        pc_next = pc + XLEN'(4);
                    end
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    discard_next = discard - CNT_W'(1);
                end
                if (redirect_valid) begin
                    pc_next = redirect_target;
`ifdef FETCH_MISALIGN_CHK_EN
                    fault_pend_next = misaligned;
`endif
                end
                if (discard_next == '0) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    state_next = fault_pend_next ? ST_FAULT : ST_FETCH;
`else
                    state_next = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            ST_FAULT: begin
                fault = 1'b1;
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (!misaligned) begin
                        fault           = 1'b0;
                        fault_pend_next = 1'b0;
                        state_next      = ST_FETCH;
                    end
                end
            end
`endif
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // PC, counters, tag queue and prefetch FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_cnt    <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            fifo_pc     <= '{default: '0};
            fifo_ix     <= '{default: '0};
            tag_q       <= '{default: '0};
`ifdef FETCH_MISALIGN_CHK_EN
            fault_pend  <= 1'b0;
`endif
        end else begin
            run         <= 1'b1;
            pc          <= pc_next;
            discard     <= discard_next;
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_CHK_EN
            fault_pend  <= fault_pend_next;
`endif
            if (req_fire) begin
                tag_q[tag_wr] <= pc;
                tag_wr        <= tag_wr + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                tag_rd <= tag_rd + PTR_W'(1);
            end
            if (flush) begin
                fifo_cnt <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
            end else begin
                if (rsp_push) begin
                    fifo_pc[fifo_wr] <= tag_q[tag_rd];
                    fifo_ix[fifo_wr] <= imem_rsp_data;
                    fifo_wr          <= fifo_wr + PTR_W'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PTR_W'(1);
                end
                fifo_cnt <= fifo_cnt + CNT_W'(rsp_push) - CNT_W'(pop);
            end
        end
    end

`ifndef SYNTHESIS
    // A push into a full FIFO without a matching pop means the credit rule was broken
    assert property (@(posedge clk) disable iff (!rst)
        !(rsp_push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stimulus for fetch_unit checked against a
// transaction-level model of the fetch stream (memory queue, credit count,
// expected request address and expected decode PC sequence).
module tb_fetch_unit;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h1000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [ILEN-1:0] imem_rsp_data  = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc    = '0;
    logic            if_valid;
    logic            if_ready = 1'b0;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_ix;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            fault;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (XLEN),
        .ILEN       (ILEN),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .if_ix          (if_ix),
        .fault          (fault)
`else
        .if_ix          (if_ix)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc        = 0;
    int          last_due   = 0;
    int          buffered   = 0;
    int          stale_cnt  = 0;
    bit          fault_pend = 1'b0;
    logic [63:0] model_pc   = RST_PC;
    logic [63:0] exp_if_pc  = RST_PC;
    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_if_ready = 100, p_redirect = 0;
    int          n_checks = 0, n_pass = 0;
    int          first_acc = -1, first_ifv = -1;
    int          n_zero_addr = 0;
    int          n_pops = 0;

    // Memory contents: a fixed scramble of the word address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = a[33:2] * 32'h9E37_79B1;
        return w ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] random_target();
        logic [63:0] t;
        int unsigned r;
        r = $urandom_range(7);
        t = {32'h0, $urandom} & 64'h0000_0000_000F_FFFC;
        if (r == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | (t & 64'hC);
        if (r == 1) t = t | 64'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        mq.delete();
        buffered   = 0;
        stale_cnt  = 0;
        fault_pend = 1'b0;
        model_pc   = RST_PC;
        exp_if_pc  = RST_PC;
        last_due   = cyc;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_ix", if_ix, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("rst_fault", fault, 0);
`endif
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step(input bit force_redir, input logic [63:0] force_pc);
        bit          redir, rsp, req_fire, pop, exp_req, exp_ifv, in_fault;
        logic [63:0] rpc, tgt;
        mreq_t       m;
        int          due;
        @(negedge clk);
        redir = force_redir || (int'($urandom_range(99)) < p_redirect);
        rpc   = force_redir ? force_pc : random_target();
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = int'($urandom_range(99)) < p_ready;
        if_ready       = int'($urandom_range(99)) < p_if_ready;
        rsp = 1'b0;
        if (mq.size() > 0) rsp = (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : ILEN'($urandom);
        #1;
`ifdef FETCH_MISALIGN_CHK_EN
        in_fault = fault_pend && (stale_cnt == 0);
        check("fault", fault, in_fault && !(redir && rpc[1:0] == 2'b00));
`else
        in_fault = 1'b0;
`endif
        exp_req = !redir && (stale_cnt == 0) && !in_fault && (mq.size() + buffered < DEPTH);
        exp_ifv = (buffered > 0) && !redir;
        check("req_valid", imem_req_valid, exp_req);
        if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
        check("if_valid", if_valid, exp_ifv);
        if (if_valid) begin
            check("if_pc", if_pc, exp_if_pc);
            check("if_ix", if_ix, mem_word(exp_if_pc));
        end
        req_fire = imem_req_valid && imem_req_ready;
        pop      = if_valid && if_ready;
        if (req_fire && first_acc < 0) first_acc = cyc;
        if (if_valid && first_ifv < 0) first_ifv = cyc;
        if (req_fire && imem_req_addr == 64'h0) n_zero_addr++;
        if (rsp) begin
            m = mq.pop_front();
            if (m.stale) stale_cnt--;
            else if (!redir) buffered++;
        end
        if (pop) begin
            if (buffered > 0) buffered--;
            exp_if_pc = exp_if_pc + 64'd4;
            n_pops++;
        end
        if (req_fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: model_pc, due: due, stale: 1'b0});
            model_pc = model_pc + 64'd4;
        end
        if (redir) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            stale_cnt = mq.size();
            buffered  = 0;
`ifdef FETCH_MISALIGN_CHK_EN
            tgt        = rpc;
            fault_pend = (rpc[1:0] != 2'b00);
`else
            tgt = rpc & ~64'd3;
`endif
            model_pc  = tgt;
            exp_if_pc = tgt;
        end
        cyc++;
    endtask

    task automatic run_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 64'h0);
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Straight-line stream, latency 1, decode always ready
        lat_min = 1; lat_max = 1; p_ready = 100; p_if_ready = 100; p_redirect = 0;
        run_steps(20);
        check("first_ifv_latency", 64'(first_ifv - first_acc), 64'd2);

        // Decode stalled: credits fill up, requests stop
        p_if_ready = 0;
        run_steps(10);
        check("bp_live", 64'(mq.size() + buffered), 64'(DEPTH));
        check("bp_req_valid", imem_req_valid, 0);
        p_if_ready = 100;
        run_steps(10);

        // Redirect with three requests in flight, latency 3
        lat_min = 3; lat_max = 3;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            step(1'b0, 64'h0);
            ok = (mq.size() == 3) && (stale_cnt == 0);
        end
        if (!ok) check("redir3_setup_timeout", 0, 1);
        n_pops = 0;
        step(1'b1, 64'h2000);
        run_steps(25);
        check("redir3_progress", n_pops > 0, 1);

        // Redirect colliding with a response and a ready decode, then re-redirect in flush
        lat_min = 2; lat_max = 3;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step(1'b0, 64'h0);
            if (mq.size() > 1 && buffered > 0) ok = (mq[0].due <= cyc);
        end
        if (!ok) check("collide_setup_timeout", 0, 1);
        step(1'b1, 64'h2800);
        check("collide_in_flush", stale_cnt > 0, 1);
        step(1'b1, 64'h3000);
        n_pops = 0;
        run_steps(25);
        check("collide_progress", n_pops > 0, 1);

        // Address wrap at the top of the address space
        lat_min = 1; lat_max = 2;
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        run_steps(15);
        check("wrap_zero_req", n_zero_addr > 0, 1);

        // Misaligned redirect, then an aligned one
        step(1'b1, 64'h2002);
        run_steps(10);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_fault", fault, 1);
`endif
        step(1'b1, 64'h2004);
        run_steps(15);

        // Reset in the middle of traffic; responses during reset are ignored
        lat_min = 2; lat_max = 3;
        run_steps(7);
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ILEN'($urandom);
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_if_valid", if_valid, 0);
        imem_rsp_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_steps(20);

        // Random traffic
        lat_min = 1; lat_max = 4; p_ready = 70; p_if_ready = 70; p_redirect = 3;
        run_steps(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
